// File: rtl/conv_pass_controller_if.sv
// Control bundle between the convolution pass controller and its
// surroundings: job start/config from the top level, progress flags from the
// stride counter and psum buffer, and the resulting datapath controls.
interface conv_pass_controller_if #(
    parameter int ROW_W  = 3,
    parameter int PASS_W = 4
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [ROW_W-1:0]  rows_cfg;
    logic [PASS_W-1:0] num_passes;
    logic              row_done;
    logic              stride_count_flag;
    logic              psum_done;
    logic              psum_buf_empty;
    logic              psum_empty;

    logic              reset_all;
    logic              if_read_start;
    logic              filter_read_start;
    logic              start_rd_gen;
    logic              clear_regs;
    logic              reset_filter;
    logic              go_next_row;
    logic              accumulate;
    logic              psum_ren;
    logic              psum_same_addr;
    logic              usage_stride_pos_ld;
    logic [ROW_W-1:0]  row_idx;
    logic [PASS_W-1:0] pass_idx;
    logic              busy;
    logic              done;

    // Controller side
    modport slave (
        input  start, abort, mode, rows_cfg, num_passes, row_done,
               stride_count_flag, psum_done, psum_buf_empty, psum_empty,
        output reset_all, if_read_start, filter_read_start, start_rd_gen,
               clear_regs, reset_filter, go_next_row, accumulate, psum_ren,
               psum_same_addr, usage_stride_pos_ld, row_idx, pass_idx, busy, done
    );

    // Top-level / datapath side
    modport master (
        output start, abort, mode, rows_cfg, num_passes, row_done,
               stride_count_flag, psum_done, psum_buf_empty, psum_empty,
        input  reset_all, if_read_start, filter_read_start, start_rd_gen,
               clear_regs, reset_filter, go_next_row, accumulate, psum_ren,
               psum_same_addr, usage_stride_pos_ld, row_idx, pass_idx, busy, done
    );
endinterface

// File: rtl/conv_pass_controller.sv
// Sequences multi-row, multi-pass convolution jobs (row target per pass
// chosen by mode) and an accumulate-only psum drain; exposes row/pass
// indices and busy/done status.
module conv_pass_controller #(
    parameter int NUM_ROWS = 4,
    parameter int ROW_W    = 3,
    parameter int PASS_W   = 4
) (
    input logic clk,
    input logic rst,
    conv_pass_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, READY, ROW, PASS_END, ACCUM, DONE} state_t;

    localparam logic [ROW_W-1:0]  MAX_ROWS = ROW_W'(NUM_ROWS);
    localparam logic [ROW_W-1:0]  ONE_ROW  = ROW_W'(1);
    localparam logic [PASS_W-1:0] ONE_PASS = PASS_W'(1);

    state_t            state, state_nxt;
    logic [ROW_W-1:0]  row_q, row_nxt;
    logic [PASS_W-1:0] pass_q, pass_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic [ROW_W-1:0]  cfg_q, cfg_nxt;
    logic [ROW_W-1:0]  tgt;
    logic [PASS_W-1:0] np_eff;
    logic              row_more;
    logic              pass_last;

    // Row target derived from the mode/row count latched in READY, so the
    // target stays fixed for the whole pass.
    always_comb begin
        tgt = ONE_ROW;
        case (mode_q)
            2'd1: tgt = MAX_ROWS;
            2'd2: begin
                if (cfg_q == '0)
                    tgt = ONE_ROW;
                else if (cfg_q > MAX_ROWS)
                    tgt = MAX_ROWS;
                else
                    tgt = cfg_q;
            end
            default: tgt = ONE_ROW;
        endcase
        row_more  = (row_q < (tgt - ONE_ROW));
        np_eff    = (bus.num_passes == '0) ? ONE_PASS : bus.num_passes;
        pass_last = (pass_q >= (np_eff - ONE_PASS));
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            row_q  <= '0;
            pass_q <= '0;
            mode_q <= '0;
            cfg_q  <= '0;
        end else begin
            state  <= state_nxt;
            row_q  <= row_nxt;
            pass_q <= pass_nxt;
            mode_q <= mode_nxt;
            cfg_q  <= cfg_nxt;
        end
    end

    // Next-state, counter updates and control outputs; start/abort override last
    always_comb begin
        state_nxt = state;
        row_nxt   = row_q;
        pass_nxt  = pass_q;
        mode_nxt  = mode_q;
        cfg_nxt   = cfg_q;

        bus.reset_all           = 1'b0;
        bus.if_read_start       = 1'b0;
        bus.filter_read_start   = 1'b0;
        bus.start_rd_gen        = 1'b0;
        bus.clear_regs          = 1'b0;
        bus.reset_filter        = 1'b0;
        bus.go_next_row         = 1'b0;
        bus.accumulate          = 1'b0;
        bus.psum_ren            = 1'b0;
        bus.psum_same_addr      = 1'b1;
        bus.usage_stride_pos_ld = 1'b1;
        bus.done                = 1'b0;
        bus.busy                = (state != IDLE);
        bus.row_idx             = row_q;
        bus.pass_idx            = pass_q;

        case (state)
            IDLE: begin
                bus.reset_all = 1'b1;
            end
            INIT: begin
                bus.if_read_start     = 1'b1;
                bus.filter_read_start = 1'b1;
                bus.reset_all         = bus.start;
                state_nxt             = READY;
            end
            READY: begin
                bus.start_rd_gen = 1'b1;
                mode_nxt         = bus.mode;
                cfg_nxt          = bus.rows_cfg;
                state_nxt        = (bus.mode == 2'd3) ? ACCUM : ROW;
            end
            ROW: begin
                bus.clear_regs          = bus.psum_done | bus.stride_count_flag;
                bus.usage_stride_pos_ld = ~row_more;
                if (bus.row_done) begin
                    if (row_more) begin
                        row_nxt = row_q + ONE_ROW;
                        // the row advance is cancelled by start/abort, so its strobes are too
                        bus.go_next_row  = ~(bus.start | bus.abort);
                        bus.reset_filter = ~(bus.start | bus.abort);
                    end else begin
                        state_nxt = PASS_END;
                    end
                end
            end
            PASS_END: begin
                if (pass_last) begin
                    state_nxt = DONE;
                end else begin
                    pass_nxt  = pass_q + ONE_PASS;
                    row_nxt   = '0;
                    state_nxt = READY;
                end
            end
            ACCUM: begin
                bus.psum_ren       = 1'b1;
                bus.psum_same_addr = 1'b0;
                bus.accumulate     = ~bus.psum_buf_empty & ~bus.psum_empty;
                if (bus.psum_empty)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
                row_nxt   = '0;
                pass_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (bus.start) begin
            state_nxt = INIT;
            row_nxt   = '0;
            pass_nxt  = '0;
        end else if (bus.abort) begin
            state_nxt = IDLE;
            row_nxt   = '0;
            pass_nxt  = '0;
        end
    end
endmodule

// File: tb/tb_conv_pass_controller.sv
// Randomized bench for conv_pass_controller: stimulus tasks track the job
// phase and push expected row-advance, accumulate and done events; a
// negedge monitor checks per-phase controls and pops events as they appear.
module tb_conv_pass_controller;
    localparam int NR = 4;

    localparam int P_IDLE = 0, P_INIT = 1, P_READY = 2, P_ROW = 3,
                   P_PEND = 4, P_ACC = 5, P_DONE = 6;
    localparam int K_GNR = 0, K_DONE = 1, K_ACC = 2;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    ev_t  sb[$];
    ev_t  mon_e;
    int   cyc = 0;
    int   compares = 0;
    int   fails = 0;
    int   ph = P_IDLE;
    int   m_r = 0, m_p = 0, m_t = 1;
    int   j_mode, j_rc, j_np;

    conv_pass_controller_if #(.ROW_W(3), .PASS_W(4)) bus ();

    conv_pass_controller #(.NUM_ROWS(NR), .ROW_W(3), .PASS_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        compares++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int t_of(input int m, input int rc);
        if (m == 1) return NR;
        if (m == 2) return (rc == 0) ? 1 : ((rc > NR) ? NR : rc);
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        bus.start             = 1'b0;
        bus.abort             = 1'b0;
        bus.row_done          = 1'b0;
        bus.psum_done         = 1'($urandom_range(0, 1));
        bus.stride_count_flag = 1'($urandom_range(0, 1));
        bus.psum_buf_empty    = 1'($urandom_range(0, 1));
        bus.psum_empty        = 1'($urandom_range(0, 1));
        bus.mode              = 2'($urandom_range(0, 3));
        bus.rows_cfg          = 3'($urandom_range(0, 7));
    endtask

    // Issued from the current window; returns in the first ROW/ACCUM window.
    task automatic begin_job(input int m, input int rc, input int np, input int hold);
        j_mode = m; j_rc = rc; j_np = np;
        bus.start      = 1'b1;
        bus.num_passes = 4'(np);
        tick();
        ph = P_INIT; m_r = 0; m_p = 0;
        for (int i = 1; i < hold; i++) begin
            bus.start = 1'b1;
            tick();
        end
        tick();
        ph = P_READY;
        bus.mode = 2'(m); bus.rows_cfg = 3'(rc);
        m_t = t_of(m, rc);
        tick();
        ph = (m == 3) ? P_ACC : P_ROW;
        m_r = 0;
    endtask

    // Issue row_done pulses for the job; stop_after >= 0 leaves the job in ROW.
    task automatic do_rows(input int stop_after);
        int t, npe, k;
        t = t_of(j_mode, j_rc);
        npe = (j_np == 0) ? 1 : j_np;
        k = 0;
        for (int p = 0; p < npe; p++) begin
            for (int r = 0; r < t; r++) begin
                if (k == stop_after) return;
                k++;
                repeat ($urandom_range(0, 2)) tick();
                bus.row_done = 1'b1;
                if (r < t - 1) begin
                    sb.push_back('{kind: K_GNR, a: r, b: p});
                    tick();
                    m_r = r + 1;
                end else begin
                    if (p == npe - 1) sb.push_back('{kind: K_DONE, a: cyc + 2, b: 0});
                    tick();
                    ph = P_PEND;
                    bus.row_done = 1'($urandom_range(0, 1));
                    tick();
                    if (p == npe - 1) begin
                        ph = P_DONE;
                        bus.row_done = 1'($urandom_range(0, 1));
                        tick();
                        ph = P_IDLE; m_r = 0; m_p = 0;
                    end else begin
                        ph = P_READY;
                        bus.mode = 2'(j_mode); bus.rows_cfg = 3'(j_rc);
                        bus.row_done = 1'($urandom_range(0, 1));
                        tick();
                        ph = P_ROW; m_r = 0; m_p = p + 1;
                    end
                end
            end
        end
    endtask

    task automatic do_accum(input int n);
        int pat[3] = '{0, 1, 0};
        for (int i = 0; i < n; i++) begin
            bus.psum_empty = 1'b0;
            bus.psum_buf_empty = (i < 3) ? 1'(pat[i]) : 1'($urandom_range(0, 1));
            sb.push_back('{kind: K_ACC, a: (bus.psum_buf_empty ? 0 : 1), b: 0});
            tick();
        end
        bus.psum_empty = 1'b1;
        sb.push_back('{kind: K_ACC, a: 0, b: 0});
        sb.push_back('{kind: K_DONE, a: cyc + 1, b: 0});
        tick();
        ph = P_DONE;
        tick();
        ph = P_IDLE; m_r = 0; m_p = 0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_reset_all"}, bus.reset_all, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_row_idx"}, bus.row_idx, 0);
        chk({tag, "_pass_idx"}, bus.pass_idx, 0);
        chk({tag, "_psum_same_addr"}, bus.psum_same_addr, 1);
        chk({tag, "_stride_ld"}, bus.usage_stride_pos_ld, 1);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    // Per-window monitor: phase-level control checks plus scoreboard pops
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", bus.busy, int'(ph != P_IDLE));
            chk("reset_all", bus.reset_all, int'(ph == P_IDLE || (ph == P_INIT && bus.start)));
            chk("if_read_start", bus.if_read_start, int'(ph == P_INIT));
            chk("filter_read_start", bus.filter_read_start, int'(ph == P_INIT));
            chk("start_rd_gen", bus.start_rd_gen, int'(ph == P_READY));
            chk("psum_ren", bus.psum_ren, int'(ph == P_ACC));
            chk("psum_same_addr", bus.psum_same_addr, int'(ph != P_ACC));
            chk("clear_regs", bus.clear_regs,
                int'(ph == P_ROW && (bus.psum_done || bus.stride_count_flag)));
            chk("stride_ld", bus.usage_stride_pos_ld, int'(!(ph == P_ROW && m_r < m_t - 1)));
            chk("done", bus.done, int'(ph == P_DONE));
            if (ph == P_ROW || ph == P_IDLE || ph == P_INIT) begin
                chk("row_idx", bus.row_idx, m_r);
                chk("pass_idx", bus.pass_idx, m_p);
            end
            if (bus.go_next_row || bus.reset_filter) begin
                chk("reset_filter_with_gnr", bus.reset_filter, bus.go_next_row);
                chk("gnr_expected", 1, int'(sb.size() > 0 && sb[0].kind == K_GNR));
                if (sb.size() > 0 && sb[0].kind == K_GNR) begin
                    mon_e = sb.pop_front();
                    chk("gnr_row", bus.row_idx, mon_e.a);
                    chk("gnr_pass", bus.pass_idx, mon_e.b);
                end
            end
            if (bus.done) begin
                chk("done_expected", 1, int'(sb.size() > 0 && sb[0].kind == K_DONE));
                if (sb.size() > 0 && sb[0].kind == K_DONE) begin
                    mon_e = sb.pop_front();
                    chk("done_cycle", cyc, mon_e.a);
                end
            end
            if (bus.psum_ren) begin
                chk("acc_expected", 1, int'(sb.size() > 0 && sb[0].kind == K_ACC));
                if (sb.size() > 0 && sb[0].kind == K_ACC) begin
                    mon_e = sb.pop_front();
                    chk("accumulate", bus.accumulate, mon_e.a);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active, expected finish");
        $fatal(1);
    end

    initial begin
        int m;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.mode = '0; bus.rows_cfg = '0;
        bus.num_passes = '0; bus.row_done = 1'b0; bus.stride_count_flag = 1'b0;
        bus.psum_done = 1'b0; bus.psum_buf_empty = 1'b1; bus.psum_empty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // full rows, two passes
        begin_job(1, 0, 2, 1); do_rows(-1);
        // row target variants
        begin_job(2, 0, 1, 1); do_rows(-1);
        begin_job(2, 7, 1, 1); do_rows(-1);
        begin_job(0, 5, 1, 1); do_rows(-1);
        // accumulate-only drain
        begin_job(3, 0, 1, 1); do_accum(5);
        // restart mid-job at row 2 of pass 1, start held two cycles
        begin_job(1, 0, 2, 1); do_rows(6);
        begin_job(1, 0, 2, 2); do_rows(-1);
        // abort together with row_done, then start+abort together
        begin_job(1, 0, 1, 1); do_rows(1);
        bus.row_done = 1'b1; bus.abort = 1'b1;
        tick();
        ph = P_IDLE; m_r = 0; m_p = 0;
        bus.abort = 1'b1;
        begin_job(2, 3, 1, 1); do_rows(-1);
        // asynchronous reset in the middle of ROW
        begin_job(1, 0, 1, 1); do_rows(2);
        #2 rst = 1'b1;
        #1 reset_checks("mid_row_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        ph = P_IDLE; m_r = 0; m_p = 0;
        tick();
        // random jobs
        repeat (10) begin
            m = $urandom_range(0, 3);
            if (m == 3) begin
                begin_job(3, 0, 1, $urandom_range(1, 2));
                do_accum($urandom_range(1, 6));
            end else begin
                begin_job(m, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(1, 2));
                do_rows(-1);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule

// File: doc/conv_pass_controller.md
Name: conv_pass_controller

Overview:
Parametrised successor to the CNN PE mode controller. It sequences multi-row, multi-pass convolution passes with a per-pass row target chosen by mode: single row, all NUM_ROWS, or a runtime row count. It also runs an accumulate-only psum drain, and exposes row/pass indices plus busy/done status. It sits between the top-level start logic and the IF/filter read generators, stride counter and psum buffer datapath.

Parameters:
NUM_ROWS, 4, maximum filter rows per pass (>=1).
ROW_W, 3, width of row_idx/rows_cfg; must hold NUM_ROWS.
PASS_W, 4, width of num_passes/pass_idx.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin/restart job.
abort  in  1  synchronous job cancel.
mode  in  2  0 single-row, 1 NUM_ROWS rows, 2 rows_cfg rows, 3 accumulate-only.
rows_cfg  in  ROW_W  row target for mode 2.
num_passes  in  PASS_W  passes per job (0 treated as 1).
row_done  in  1  stride position load: current row finished.
stride_count_flag  in  1  stride count reached.
psum_done  in  1  psum for current window complete.
psum_buf_empty  in  1  P-sum staging buffer empty.
psum_empty  in  1  psum scratchpad empty.
reset_all, if_read_start, filter_read_start, start_rd_gen, clear_regs, reset_filter, go_next_row, accumulate, psum_ren  out  1 each  datapath controls.
psum_same_addr  out  1  psum read address hold.
usage_stride_pos_ld  out  1  stride position load enable.
row_idx  out  ROW_W  current row in pass.
pass_idx  out  PASS_W  current pass.
busy  out  1  state != IDLE.
done  out  1  one-cycle job-complete pulse.

Behaviour:
- States: IDLE, INIT, READY, ROW, PASS_END, ACCUM, DONE. All control outputs are Moore/combinational from state, registered counters and inputs. Counters, state and mode_q are registered.
- Reset: state=IDLE, row_idx=0, pass_idx=0, mode_q=0. Outputs: reset_all=1, psum_same_addr=1, usage_stride_pos_ld=1, all others 0.
- Priority per cycle: rst > start > abort > normal transition.
- start (any state): next state INIT; row_idx and pass_idx cleared.
- abort: next state IDLE, counters cleared, no done pulse.
- Output defaults: psum_same_addr=1, usage_stride_pos_ld=1, all others 0.
- IDLE: reset_all=1. Go to INIT on start.
- INIT: if_read_start=1, filter_read_start=1, reset_all=start. Stay while start is high, else go to READY.
- READY: start_rd_gen=1; mode_q<=mode. Mode changes outside READY are ignored. If mode==3, go to ACCUM. Otherwise go to ROW with target T:
  - mode 0: T=1.
  - mode 1: T=NUM_ROWS.
  - mode 2: T=rows_cfg, with 0 treated as 1 and values >NUM_ROWS clamped to NUM_ROWS.
  - T is latched.
- ROW: clear_regs=psum_done|stride_count_flag; usage_stride_pos_ld=0 while row_idx<T-1.
  - On row_done with row_idx<T-1: row_idx++, go_next_row=1 and reset_filter=1 in that cycle; stay in ROW.
  - On row_done with row_idx==T-1: go to PASS_END.
  - row_done together with clear conditions: both actions occur.
- PASS_END (1 cycle): if pass_idx==max(num_passes,1)-1, go to DONE. Else pass_idx++, row_idx=0, go to READY. pass_idx wraps never; num_passes is sampled here.
- ACCUM: psum_ren=1, psum_same_addr=0, accumulate=~psum_buf_empty&~psum_empty. On psum_empty, go to DONE. accumulate is 0 in that same cycle.
- DONE: done=1 for exactly one cycle, then IDLE.
- row_done outside ROW is ignored.
- Latency: from the final row_done cycle t, PASS_END at t+1, done at t+2, IDLE at t+3.

Test Plan:
1. Assert rst mid-ROW -> immediately IDLE; reset_all=1, busy=0, row_idx=0, pass_idx=0, psum_same_addr=1, usage_stride_pos_ld=1.
2. NUM_ROWS=4, mode=1, num_passes=2, start pulse, 8 spaced row_done pulses -> go_next_row/reset_filter pulse 3x per pass; row_idx 0..3 each pass; pass_idx 0->1; done high exactly 2 cycles after the 8th row_done; then IDLE.
3. mode=2 with rows_cfg=0, then rows_cfg=7 (num_passes=1) -> pass ends after 1 and after 4 row_done respectively; mode=0 -> after 1.
4. mode=3, psum_empty=0, psum_buf_empty pattern 0,1,0 -> accumulate 1,0,1 with psum_ren=1 and psum_same_addr=0 throughout; psum_empty=1 -> DONE next cycle, done pulse.
5. start asserted in ROW with row_idx=2, pass_idx=1 -> INIT next cycle, counters 0, reset_all=1 while start held, READY one cycle after start drops.
6. abort in ROW with simultaneous row_done -> IDLE next cycle; no done pulse, no row_idx increment. Same cycle start+abort -> INIT.
